// File: rtl/qspi_mem_responder.sv
// QSPI quad-I/O memory responder: oversamples the master's SCK/CS/IO in the clk_i domain
// and serves read (0x0B) and write (0x02) traffic from a byte-addressed internal array.
module qspi_mem_responder #(
    parameter int MEM_BYTES    = 65536,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        qspi_ck_i,
    input  logic        qspi_cs_i,
    input  logic [3:0]  qspi_io_i,
    output logic [3:0]  qspi_io_o,
    output logic [3:0]  qspi_io_t,
    input  logic        ld_we_i,
    input  logic [23:0] ld_addr_i,
    input  logic [7:0]  ld_data_i,
    output logic        busy_o
);

    // state  | meaning
    // IDLE   | cs high, bus released
    // CMD    | shifting in the two command nibbles
    // ADDR   | shifting in the six address nibbles
    // DUMMY  | counting dummy SCK rises before read data
    // RDATA  | driving read nibbles on SCK falls
    // WDATA  | assembling write bytes from nibbles on SCK rises
    // IGNORE | unknown command, waiting for cs to rise

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    logic [1:0]    ck_s, cs_s;
    logic [3:0]    io_s1, io_s2;
    logic          ck_d;
    logic          ck_rise, ck_fall, cs_sync;

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic [3:0]    cmd_hi_q;
    logic          is_read_q;
    logic [AW-1:0] addr_q;
    logic          phase_q;
    logic [3:0]    wr_hi_q;
    logic [7:0]    rd_q;

    logic [7:0]    mem [MEM_BYTES];

    logic          wr_en;
    logic [7:0]    wr_data;
    logic [AW-1:0] ld_idx;
    logic          unused_ld_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ck_s  <= 2'b00;
            cs_s  <= 2'b11;
            io_s1 <= 4'h0;
            io_s2 <= 4'h0;
            ck_d  <= 1'b0;
        end else begin
            ck_s  <= {ck_s[0], qspi_ck_i};
            cs_s  <= {cs_s[0], qspi_cs_i};
            io_s1 <= qspi_io_i;
            io_s2 <= io_s1;
            ck_d  <= ck_s[1];
        end
    end

    assign ck_rise = ck_s[1] & ~ck_d;
    assign ck_fall = ~ck_s[1] & ck_d;
    assign cs_sync = cs_s[1];

    assign wr_en   = (state_q == ST_WDATA) && !cs_sync && ck_rise && phase_q;
    assign wr_data = {wr_hi_q, io_s2};
    assign ld_idx  = ld_addr_i[AW-1:0];
    assign unused_ld_addr = ^ld_addr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            cmd_hi_q  <= 4'h0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            wr_hi_q   <= 4'h0;
            qspi_io_o <= 4'h0;
            qspi_io_t <= 4'hF;
        end else if (state_q != ST_IDLE && cs_sync) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            qspi_io_o <= 4'h0;
            qspi_io_t <= 4'hF;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_sync) begin
                        state_q <= ST_CMD;
                        cnt_q   <= 8'd1;
                    end
                end
                ST_CMD: begin
                    if (ck_rise) begin
                        if (cnt_q == 8'd0) begin
                            if ({cmd_hi_q, io_s2} == 8'h0B || {cmd_hi_q, io_s2} == 8'h02) begin
                                state_q   <= ST_ADDR;
                                cnt_q     <= 8'd5;
                                is_read_q <= ({cmd_hi_q, io_s2} == 8'h0B);
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end else begin
                            cmd_hi_q <= io_s2;
                            cnt_q    <= cnt_q - 8'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ck_rise) begin
                        // Only the low AW bits survive the shift, giving the modulo for free.
                        addr_q <= {addr_q[AW-5:0], io_s2};
                        if (cnt_q == 8'd0) begin
                            phase_q <= 1'b0;
                            if (!is_read_q) begin
                                state_q <= ST_WDATA;
                            end else if (DUMMY_CYCLES > 0) begin
                                state_q <= ST_DUMMY;
                                cnt_q   <= 8'(DUMMY_CYCLES - 1);
                            end else begin
                                state_q <= ST_RDATA;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (ck_rise) begin
                        if (cnt_q == 8'd0) begin
                            state_q <= ST_RDATA;
                            phase_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (ck_fall) begin
                        qspi_io_t <= 4'h0;
                        if (!phase_q) begin
                            qspi_io_o <= rd_q[7:4];
                            phase_q   <= 1'b1;
                        end else begin
                            qspi_io_o <= rd_q[3:0];
                            phase_q   <= 1'b0;
                            addr_q    <= addr_q + AW'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (ck_rise) begin
                        if (!phase_q) begin
                            wr_hi_q <= io_s2;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            addr_q  <= addr_q + AW'(1);
                        end
                    end
                end
                ST_IGNORE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Backdoor write is issued last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        rd_q <= mem[addr_q];
        if (wr_en) mem[addr_q] <= wr_data;
        if (ld_we_i) mem[ld_idx] <= ld_data_i;
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench for qspi_mem_responder: a bit-banged QSPI master checked against an associative-array
// memory model, with directed scenarios followed by randomized write/read traffic.
module tb_qspi_mem_responder;

    localparam int MEM   = 65536;
    localparam int DUMMY = 2;
    localparam int HP    = 6;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        qspi_ck_i;
    logic        qspi_cs_i;
    logic [3:0]  qspi_io_i;
    logic [3:0]  qspi_io_o;
    logic [3:0]  qspi_io_t;
    logic        ld_we_i;
    logic [23:0] ld_addr_i;
    logic [7:0]  ld_data_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [int];

    qspi_mem_responder #(.MEM_BYTES(MEM), .DUMMY_CYCLES(DUMMY)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .qspi_ck_i (qspi_ck_i),
        .qspi_cs_i (qspi_cs_i),
        .qspi_io_i (qspi_io_i),
        .qspi_io_o (qspi_io_o),
        .qspi_io_t (qspi_io_t),
        .ld_we_i   (ld_we_i),
        .ld_addr_i (ld_addr_i),
        .ld_data_i (ld_data_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int idx(input logic [23:0] a, input int off);
        return (int'(a) + off) % MEM;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] rd, output logic [3:0] t);
        qspi_io_i = nib;
        wait_clk(HP);
        rd = qspi_io_o;
        t  = qspi_io_t;
        qspi_ck_i = 1'b1;
        wait_clk(HP);
        qspi_ck_i = 1'b0;
    endtask

    task automatic send_nibbles(input logic [31:0] v, input int n, input string tag);
        logic [3:0] rd, t;
        for (int i = n - 1; i >= 0; i--) begin
            sck_cycle(v[i*4 +: 4], rd, t);
            check(tag, 32'(t), 32'hF);
        end
    endtask

    task automatic begin_frame(input logic [7:0] cmd, input logic [23:0] addr);
        qspi_cs_i = 1'b0;
        send_nibbles(32'(cmd), 2, "cmd_iot");
        send_nibbles(32'(addr), 6, "addr_iot");
    endtask

    task automatic end_frame();
        wait_clk(HP);
        qspi_cs_i = 1'b1;
        wait_clk(2 * HP);
        check("idle_iot", 32'(qspi_io_t), 32'hF);
        check("idle_busy", 32'(busy_o), 32'h0);
    endtask

    task automatic backdoor(input logic [23:0] a, input logic [7:0] d);
        ld_we_i   = 1'b1;
        ld_addr_i = a;
        ld_data_i = d;
        wait_clk(1);
        ld_we_i   = 1'b0;
        model[idx(a, 0)] = d;
    endtask

    task automatic qspi_write(input logic [23:0] a, input logic [7:0] d [4], input int n);
        begin_frame(8'h02, a);
        for (int i = 0; i < n; i++) begin
            send_nibbles(32'(d[i]), 2, "wdata_iot");
            model[idx(a, i)] = d[i];
        end
        end_frame();
    endtask

    task automatic read_data(input logic [23:0] a, input int first, input int n);
        logic [3:0] hi, lo, t0, t1;
        for (int i = first; i < first + n; i++) begin
            sck_cycle(4'h0, hi, t0);
            sck_cycle(4'h0, lo, t1);
            check("rdata_iot_hi", 32'(t0), 32'h0);
            check("rdata_iot_lo", 32'(t1), 32'h0);
            check($sformatf("rdata@%0h", idx(a, i)), 32'({hi, lo}), 32'(model[idx(a, i)]));
        end
    endtask

    task automatic read_header(input logic [23:0] a);
        logic [3:0] rd, t;
        begin_frame(8'h0B, a);
        for (int k = 0; k < DUMMY; k++) begin
            sck_cycle(4'h0, rd, t);
            check("dummy_iot", 32'(t), 32'hF);
        end
    endtask

    task automatic qspi_read(input logic [23:0] a, input int n);
        read_header(a);
        read_data(a, 0, n);
        end_frame();
    endtask

    initial begin
        logic [7:0]  d [4];
        logic [3:0]  rd, t;
        logic [23:0] ra;
        int          n;

        rst_ni    = 1'b0;
        qspi_ck_i = 1'b0;
        qspi_cs_i = 1'b1;
        qspi_io_i = 4'h0;
        ld_we_i   = 1'b0;
        ld_addr_i = 24'h0;
        ld_data_i = 8'h0;
        wait_clk(3);
        check("rst_iot", 32'(qspi_io_t), 32'hF);
        check("rst_ioo", 32'(qspi_io_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        wait_clk(3);

        // Write then read at 0x10.
        d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        qspi_write(24'h000010, d, 2);
        qspi_read(24'h000010, 2);

        // Wrap across the top of the array.
        d = '{8'h11, 8'h22, 8'h00, 8'h00};
        qspi_write(24'(MEM - 1), d, 2);
        qspi_read(24'(MEM - 1), 2);
        qspi_read(24'h000000, 1);

        // Unknown command: bus stays released, busy until cs rises, memory untouched.
        qspi_cs_i = 1'b0;
        send_nibbles(32'h9F, 2, "ign_cmd_iot");
        send_nibbles(32'h000010FF, 8, "ign_iot");
        check("ign_busy", 32'(busy_o), 32'h1);
        end_frame();
        qspi_read(24'h000010, 2);

        // Abort after a single write nibble.
        backdoor(24'h000020, 8'h5A);
        begin_frame(8'h02, 24'h000020);
        sck_cycle(4'hF, rd, t);
        end_frame();
        qspi_read(24'h000020, 1);

        // Backdoor preload and read.
        backdoor(24'h000100, 8'hDE);
        backdoor(24'h000101, 8'hAD);
        qspi_read(24'h000100, 2);

        // Same-cycle collision: the backdoor stays asserted up to the cycle the low nibble lands.
        begin_frame(8'h02, 24'h000100);
        send_nibbles(32'h5, 1, "coll_iot");
        qspi_io_i = 4'h5;
        wait_clk(HP);
        qspi_ck_i = 1'b1;
        ld_we_i   = 1'b1;
        ld_addr_i = 24'h000100;
        ld_data_i = 8'h77;
        wait_clk(3);
        ld_we_i   = 1'b0;
        wait_clk(HP - 3);
        qspi_ck_i = 1'b0;
        end_frame();
        model[idx(24'h000100, 0)] = 8'h77;
        qspi_read(24'h000100, 2);

        // Reset during RDATA releases the bus immediately.
        read_header(24'h000100);
        sck_cycle(4'h0, rd, t);
        check("pre_rst_nib", 32'(rd), 32'h7);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_iot", 32'(qspi_io_t), 32'hF);
        check("mid_rst_ioo", 32'(qspi_io_o), 32'h0);
        qspi_cs_i = 1'b1;
        qspi_ck_i = 1'b0;
        wait_clk(3);
        rst_ni = 1'b1;
        wait_clk(3);
        check("post_rst_busy", 32'(busy_o), 32'h0);
        qspi_read(24'h000100, 2);

        // Randomized QSPI writes read back, including high address bits beyond the array.
        for (int it = 0; it < 6; it++) begin
            ra = 24'($urandom);
            n  = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            qspi_write(ra, d, n);
            qspi_read(ra, n);
        end

        // Randomized backdoor preloads read over QSPI.
        for (int it = 0; it < 3; it++) begin
            ra = 24'($urandom);
            for (int i = 0; i < 3; i++) backdoor(24'(idx(ra, i)), 8'($urandom));
            qspi_read(ra, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
